// File: rtl/lfsr_checker.sv
// PRBS-80 stream checker (x^80+x^79+x^43+x^42+1): fills history, then checks, tracks lock and resyncs after loss.
// Optional mismatch counter enabled by defining LFSR_CHECKER_ERRCNT_EN; otherwise err_cnt reads 16'h0000.
module lfsr_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        Ser_in,
  input  logic        Ser_valid,
  output logic [79:0] Par_out,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [79:0] r_par, w_par_next;
  logic [6:0]  r_fill_cnt, w_fill_next;
  logic [5:0]  r_good_cnt, w_good_next;
  logic [1:0]  r_miss_cnt, w_miss_next;
  logic        r_locked, w_locked_next;
  logic        r_err, w_err_next;
  logic        w_expected;

  // Expected bit is taken from the history before the incoming bit is shifted in.
  assign w_expected = r_par[79] ^ r_par[78] ^ r_par[42] ^ r_par[41];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_par      <= '0;
      r_fill_cnt <= '0;
      r_good_cnt <= '0;
      r_miss_cnt <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_par      <= w_par_next;
      r_fill_cnt <= w_fill_next;
      r_good_cnt <= w_good_next;
      r_miss_cnt <= w_miss_next;
      r_locked   <= w_locked_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_par_next    = r_par;
    w_fill_next   = r_fill_cnt;
    w_good_next   = r_good_cnt;
    w_miss_next   = r_miss_cnt;
    w_locked_next = r_locked;
    w_err_next    = 1'b0;
    // start wins over a coincident valid bit, which is dropped.
    if (start) begin
      w_state_next  = S_FILL;
      w_par_next    = '0;
      w_fill_next   = '0;
      w_good_next   = '0;
      w_miss_next   = '0;
      w_locked_next = 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (Ser_valid) begin
            w_par_next = {r_par[78:0], Ser_in};
            if (r_fill_cnt == 7'd79) begin
              w_fill_next  = '0;
              w_state_next = S_CHECK;
            end else begin
              w_fill_next = r_fill_cnt + 7'd1;
            end
          end
        end
        S_CHECK: begin
          if (Ser_valid) begin
            w_par_next = {r_par[78:0], Ser_in};
            if (Ser_in != w_expected) begin
              w_err_next    = 1'b1;
              w_good_next   = '0;
              w_locked_next = 1'b0;
              if (r_miss_cnt == 2'd2) begin
                w_miss_next  = '0;
                w_state_next = S_LOST;
              end else begin
                w_miss_next = r_miss_cnt + 2'd1;
              end
            end else begin
              w_miss_next = '0;
              if (r_good_cnt != 6'd32) w_good_next = r_good_cnt + 6'd1;
              if (r_good_cnt >= 6'd31) w_locked_next = 1'b1;
            end
          end
        end
        S_LOST: begin
          // History is kept for resync; this bit is shifted but neither checked nor counted.
          if (Ser_valid) w_par_next = {r_par[78:0], Ser_in};
          w_state_next  = S_FILL;
          w_fill_next   = '0;
          w_good_next   = '0;
          w_miss_next   = '0;
          w_locked_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (start) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'h0000;
`endif

  assign Par_out = r_par;
  assign locked  = r_locked;
  assign err     = r_err;
  assign state   = r_state;

endmodule
